// File: rtl/bldc_motor_supervisor.sv
// Per-motor BLDC supervisor: command latch, slew-limited duty ramp,
// periodic count snapshots and hall-fault retry/lockout sequencing.
module bldc_motor_supervisor #(
   parameter int DUTY_CYCLE_WIDTH    = 10,
   parameter int ENCODER_COUNT_WIDTH = 15,
   parameter int HALL_COUNT_WIDTH    = 7,
   parameter int RAMP_STEP           = 4,
   parameter int RAMP_DIV            = 1000,
   parameter int SAMPLE_PERIOD       = 10000,
   parameter int FAULT_HOLDOFF       = 100000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   input  logic                           cmd_en,
   input  logic [DUTY_CYCLE_WIDTH-1:0]    cmd_duty,
   input  logic                           clear_fault,
   input  logic                           hall_fault,
   input  logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
   input  logic [HALL_COUNT_WIDTH-1:0]    hall_count,
   output logic                           motor_en,
   output logic [DUTY_CYCLE_WIDTH-1:0]    motor_duty,
   output logic                           motor_reset_counts,
   output logic [ENCODER_COUNT_WIDTH-1:0] enc_snapshot,
   output logic [HALL_COUNT_WIDTH-1:0]    hall_snapshot,
   output logic                           sample_valid,
   output logic [2:0]                     state,
   output logic                           fault_latched
);

   localparam int DW  = DUTY_CYCLE_WIDTH;
   localparam int RTW = $clog2(RAMP_DIV + 1);
   localparam int STW = $clog2(SAMPLE_PERIOD + 1);
   localparam int HTW = $clog2(FAULT_HOLDOFF + 1);
   localparam int CW  = $clog2(MAX_RETRIES + 2);

   localparam logic [RTW-1:0] RAMP_LAST = RTW'(RAMP_DIV - 1);
   localparam logic [STW-1:0] SMP_LAST  = STW'(SAMPLE_PERIOD - 1);
   localparam logic [HTW-1:0] HOLD_LAST = HTW'(FAULT_HOLDOFF - 1);
   localparam logic [DW-1:0]  STEP      = DW'(RAMP_STEP);
   localparam logic [CW-1:0]  RETRY_MAX = CW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RAMP       = 3'd1,
      RUN        = 3'd2,
      FAULT_WAIT = 3'd3,
      LOCKOUT    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   target;
   logic            en_req;
   logic [RTW-1:0]  ramp_cnt;
   logic [STW-1:0]  smp_cnt;
   logic [HTW-1:0]  hold_cnt, hold_d;
   logic [CW-1:0]   retry, retry_d;
   logic [DW-1:0]   duty_d, diff, step;
   logic            ramp_tick, smp_tick;

   assign ramp_tick = (ramp_cnt == RAMP_LAST);
   assign smp_tick  = (smp_cnt == SMP_LAST);
   assign state     = state_q;

   always_comb begin
      state_d = state_q;
      duty_d  = motor_duty;
      retry_d = retry;
      hold_d  = '0;
      diff    = (target > motor_duty) ? target - motor_duty
                                      : motor_duty - target;
      step    = (diff > STEP) ? STEP : diff;
      unique case (state_q)
         IDLE: begin
            duty_d = '0;
            if (en_req) state_d = RAMP;
         end
         RAMP, RUN: begin
            if (hall_fault) begin
               state_d = FAULT_WAIT;
               duty_d  = '0;
               retry_d = retry + 1'b1;
            end else if (!en_req) begin
               state_d = IDLE;
               duty_d  = '0;
            end else if (state_q == RUN) begin
               if (target != motor_duty) state_d = RAMP;
            end else if (motor_duty == target) begin
               state_d = RUN;
               retry_d = '0;
            end else if (ramp_tick) begin
               // step is bounded by the distance, so no overshoot or wrap
               duty_d = (target > motor_duty) ? motor_duty + step
                                              : motor_duty - step;
            end
         end
         FAULT_WAIT: begin
            duty_d = '0;
            if (hold_cnt != HOLD_LAST) begin
               hold_d = hold_cnt + 1'b1;
            end else if (retry >= RETRY_MAX) begin
               state_d = LOCKOUT;
            end else if (hall_fault) begin
               retry_d = retry + 1'b1;
            end else if (en_req) begin
               state_d = RAMP;
            end else begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            duty_d = '0;
            if (clear_fault) begin
               retry_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            duty_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         target             <= '0;
         en_req             <= 1'b0;
         ramp_cnt           <= '0;
         smp_cnt            <= '0;
         hold_cnt           <= '0;
         retry              <= '0;
         motor_en           <= 1'b0;
         motor_duty         <= '0;
         motor_reset_counts <= 1'b0;
         enc_snapshot       <= '0;
         hall_snapshot      <= '0;
         sample_valid       <= 1'b0;
         fault_latched      <= 1'b0;
      end else begin
         if (cmd_valid) begin
            target <= cmd_duty;
            en_req <= cmd_en;
         end
         state_q       <= state_d;
         motor_duty    <= duty_d;
         retry         <= retry_d;
         hold_cnt      <= hold_d;
         motor_en      <= (state_d == RAMP) || (state_d == RUN);
         fault_latched <= (state_d == LOCKOUT);
         // ramp timer only runs while staying in RAMP
         if (state_q == RAMP && state_d == RAMP)
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
         else
            ramp_cnt <= '0;
         smp_cnt            <= smp_tick ? '0 : smp_cnt + 1'b1;
         sample_valid       <= smp_tick;
         motor_reset_counts <= smp_tick;
         if (smp_tick) begin
            enc_snapshot  <= enc_count;
            hall_snapshot <= hall_count;
         end
      end
   end

endmodule

// File: tb/tb_bldc_motor_supervisor.sv
// Directed self-checking bench for bldc_motor_supervisor
// with short ramp/sample/holdoff periods.
module tb_bldc_motor_supervisor;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_en;
   logic [9:0]  cmd_duty;
   logic        clear_fault;
   logic        hall_fault;
   logic [14:0] enc_count;
   logic [6:0]  hall_count;
   logic        motor_en;
   logic [9:0]  motor_duty;
   logic        motor_reset_counts;
   logic [14:0] enc_snapshot;
   logic [6:0]  hall_snapshot;
   logic        sample_valid;
   logic [2:0]  state;
   logic        fault_latched;

   int tests = 0;
   int fails = 0;

   bldc_motor_supervisor #(
      .DUTY_CYCLE_WIDTH(10),
      .ENCODER_COUNT_WIDTH(15),
      .HALL_COUNT_WIDTH(7),
      .RAMP_STEP(4),
      .RAMP_DIV(4),
      .SAMPLE_PERIOD(8),
      .FAULT_HOLDOFF(20),
      .MAX_RETRIES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_en(cmd_en),
      .cmd_duty(cmd_duty),
      .clear_fault(clear_fault),
      .hall_fault(hall_fault),
      .enc_count(enc_count),
      .hall_count(hall_count),
      .motor_en(motor_en),
      .motor_duty(motor_duty),
      .motor_reset_counts(motor_reset_counts),
      .enc_snapshot(enc_snapshot),
      .hall_snapshot(hall_snapshot),
      .sample_valid(sample_valid),
      .state(state),
      .fault_latched(fault_latched)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic en, input logic [9:0] d);
      cmd_valid = 1'b1;
      cmd_en    = en;
      cmd_duty  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_run(input logic [9:0] d, input int budget,
                           output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < budget) begin
         @(negedge clk);
         n++;
         if (state == 3'd2 && motor_duty == d) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty, sample_valid,
           motor_reset_counts, fault_latched, enc_snapshot,
           hall_snapshot} !== '0) begin
         fails++;
         $display("FAIL reset_state: state=%0d en=%0b duty=%0d sv=%0b",
                  state, motor_en, motor_duty, sample_valid);
      end
      rst = 1'b0;
      send_cmd(1'b1, 10'd250);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (motor_duty == 10'd200) ok = 1'b1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL reset_ramp_reach200: duty=%0d want 200",
                  motor_duty);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({state, motor_en, motor_duty, sample_valid} !== 14'd0) begin
         fails++;
         $display("FAIL reset_midramp: state=%0d en=%0b duty=%0d sv=%0b",
                  state, motor_en, motor_duty, sample_valid);
      end
      @(negedge clk);
      tests++;
      if (state !== 3'd0) begin
         fails++;
         $display("FAIL reset_stays_idle: state=%0d want 0", state);
      end
   endtask

   task automatic test_ramp_up();
      send_cmd(1'b1, 10'd10);
      @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty} !== {3'd1, 1'b1, 10'd0}) begin
         fails++;
         $display("FAIL ramp_up_enter: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (motor_duty !== 10'd0) begin
         fails++;
         $display("FAIL ramp_up_wait: duty=%0d want 0", motor_duty);
      end
      @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd1, 10'd4}) begin
         fails++;
         $display("FAIL ramp_up_4: state=%0d duty=%0d want 1/4",
                  state, motor_duty);
      end
      repeat (4) @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd1, 10'd8}) begin
         fails++;
         $display("FAIL ramp_up_8: state=%0d duty=%0d want 1/8",
                  state, motor_duty);
      end
      repeat (4) @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd1, 10'd10}) begin
         fails++;
         $display("FAIL ramp_up_10: state=%0d duty=%0d want 1/10",
                  state, motor_duty);
      end
      @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty} !== {3'd2, 1'b1, 10'd10}) begin
         fails++;
         $display("FAIL ramp_up_run: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
      repeat (6) @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd2, 10'd10}) begin
         fails++;
         $display("FAIL ramp_up_hold: state=%0d duty=%0d want 2/10",
                  state, motor_duty);
      end
   endtask

   task automatic test_ramp_down();
      bit ok;
      send_cmd(1'b1, 10'd100);
      wait_run(10'd100, 200, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL ramp_to_100: state=%0d duty=%0d", state, motor_duty);
      end
      send_cmd(1'b1, 10'd90);
      @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd1, 10'd100}) begin
         fails++;
         $display("FAIL ramp_down_enter: state=%0d duty=%0d want 1/100",
                  state, motor_duty);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (motor_duty !== 10'd96) begin
         fails++;
         $display("FAIL ramp_down_96: duty=%0d want 96", motor_duty);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (motor_duty !== 10'd92) begin
         fails++;
         $display("FAIL ramp_down_92: duty=%0d want 92", motor_duty);
      end
      repeat (4) @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd1, 10'd90}) begin
         fails++;
         $display("FAIL ramp_down_90: state=%0d duty=%0d want 1/90",
                  state, motor_duty);
      end
      @(negedge clk);
      tests++;
      if ({state, motor_duty} !== {3'd2, 10'd90}) begin
         fails++;
         $display("FAIL ramp_down_run: state=%0d duty=%0d want 2/90",
                  state, motor_duty);
      end
      send_cmd(1'b0, 10'd90);
      @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty} !== 14'd0) begin
         fails++;
         $display("FAIL disable_idle: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
   endtask

   task automatic test_fault_retry();
      bit ok;
      send_cmd(1'b1, 10'd10);
      wait_run(10'd10, 60, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL fault_pre_run: state=%0d duty=%0d", state, motor_duty);
      end
      hall_fault = 1'b1;
      @(negedge clk);
      hall_fault = 1'b0;
      tests++;
      if ({state, motor_en, motor_duty} !== {3'd3, 1'b0, 10'd0}) begin
         fails++;
         $display("FAIL fault_enter: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
      repeat (19) @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty} !== {3'd3, 1'b0, 10'd0}) begin
         fails++;
         $display("FAIL fault_holdoff_end: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
      @(negedge clk);
      tests++;
      if ({state, motor_en, motor_duty} !== {3'd1, 1'b1, 10'd0}) begin
         fails++;
         $display("FAIL fault_reramp: state=%0d en=%0b duty=%0d",
                  state, motor_en, motor_duty);
      end
      wait_run(10'd10, 60, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL fault_rerun: state=%0d duty=%0d", state, motor_duty);
      end
   endtask

   task automatic test_lockout();
      bit ok;
      hall_fault = 1'b1;
      @(negedge clk);
      tests++;
      if (state !== 3'd3) begin
         fails++;
         $display("FAIL lock_enter: state=%0d want 3", state);
      end
      repeat (40) @(negedge clk);
      tests++;
      if ({state, fault_latched} !== {3'd3, 1'b0}) begin
         fails++;
         $display("FAIL lock_after2: state=%0d fl=%0b want 3/0",
                  state, fault_latched);
      end
      repeat (19) @(negedge clk);
      tests++;
      if (state !== 3'd3) begin
         fails++;
         $display("FAIL lock_after3_end: state=%0d want 3", state);
      end
      @(negedge clk);
      tests++;
      if ({state, fault_latched, motor_en, motor_duty} !==
          {3'd4, 1'b1, 1'b0, 10'd0}) begin
         fails++;
         $display("FAIL lock_enter4: state=%0d fl=%0b en=%0b duty=%0d",
                  state, fault_latched, motor_en, motor_duty);
      end
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (sample_valid && motor_reset_counts) ok = 1'b1;
      end
      tests++;
      if (!ok || state !== 3'd4) begin
         fails++;
         $display("FAIL lock_sample: pulse=%0b state=%0d", ok, state);
      end
      hall_fault  = 1'b0;
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      tests++;
      if ({state, fault_latched} !== {3'd0, 1'b0}) begin
         fails++;
         $display("FAIL lock_clear: state=%0d fl=%0b want 0/0",
                  state, fault_latched);
      end
      send_cmd(1'b0, 10'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_sampling();
      bit ok;
      enc_count  = 15'd1234;
      hall_count = 7'd17;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (sample_valid) ok = 1'b1;
      end
      tests++;
      if (!ok || {enc_snapshot, hall_snapshot, motor_reset_counts} !==
          {15'd1234, 7'd17, 1'b1}) begin
         fails++;
         $display("FAIL sample_first: ok=%0b enc=%0d hall=%0d rc=%0b",
                  ok, enc_snapshot, hall_snapshot, motor_reset_counts);
      end
      enc_count  = 15'd555;
      hall_count = 7'd99;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         tests++;
         if ({sample_valid, motor_reset_counts, enc_snapshot,
              hall_snapshot} !== {2'b00, 15'd1234, 7'd17}) begin
            fails++;
            $display("FAIL sample_gap%0d: sv=%0b rc=%0b enc=%0d hall=%0d",
                     i, sample_valid, motor_reset_counts,
                     enc_snapshot, hall_snapshot);
         end
      end
      @(negedge clk);
      tests++;
      if ({sample_valid, motor_reset_counts, enc_snapshot,
           hall_snapshot} !== {2'b11, 15'd555, 7'd99}) begin
         fails++;
         $display("FAIL sample_second: sv=%0b rc=%0b enc=%0d hall=%0d",
                  sample_valid, motor_reset_counts,
                  enc_snapshot, hall_snapshot);
      end
   endtask

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_en      = 1'b0;
      cmd_duty    = '0;
      clear_fault = 1'b0;
      hall_fault  = 1'b0;
      enc_count   = '0;
      hall_count  = '0;
      @(negedge clk);
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_fault_retry();
      test_lockout();
      test_sampling();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bldc_motor_supervisor.md
Name: bldc_motor_supervisor

Overview:
Per-motor controller that sequences one BLDC_Motor instance. It accepts duty-cycle commands from the host register interface and slew-limits them onto the driver's duty_cycle/en inputs. It periodically snapshots and clears the driver's encoder/hall counters, and recovers from hall faults with bounded retries. It sits between the host command decoder and BLDC_Motor; one instance per motor.

Parameters:
DUTY_CYCLE_WIDTH, 10, width of duty command/output
ENCODER_COUNT_WIDTH, 15, width of enc_count
HALL_COUNT_WIDTH, 7, width of hall_count
RAMP_STEP, 4, max duty change per ramp tick
RAMP_DIV, 1000, clocks between ramp ticks (>=1)
SAMPLE_PERIOD, 10000, clocks between count snapshots (>=2)
FAULT_HOLDOFF, 100000, clocks motor held off after a hall fault
MAX_RETRIES, 3, consecutive faults before lockout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  single-cycle strobe: latch cmd_en/cmd_duty
cmd_en  in  1  requested motor enable
cmd_duty  in  DUTY_CYCLE_WIDTH  requested target duty
clear_fault  in  1  exits LOCKOUT
hall_fault  in  1  from BLDC_Motor.hall_fault
enc_count  in  ENCODER_COUNT_WIDTH  from BLDC_Motor
hall_count  in  HALL_COUNT_WIDTH  from BLDC_Motor
motor_en  out  1  to BLDC_Motor.en
motor_duty  out  DUTY_CYCLE_WIDTH  to BLDC_Motor.duty_cycle
motor_reset_counts  out  1  to BLDC_Motor.reset_counts
enc_snapshot  out  ENCODER_COUNT_WIDTH  last sampled encoder count
hall_snapshot  out  HALL_COUNT_WIDTH  last sampled hall count
sample_valid  out  1  one-cycle pulse when snapshots update
state  out  3  IDLE=0 RAMP=1 RUN=2 FAULT_WAIT=3 LOCKOUT=4
fault_latched  out  1  high in LOCKOUT

Behaviour:
- Reset: all outputs 0; state=IDLE; target=0, en_req=0, retry count=0; ramp, sample and holdoff timers=0.
- Command latch: cmd_valid loads target/en_req on the next edge in every state, including FAULT_WAIT/LOCKOUT. Only the latest command is kept.
- Priority per cycle: rst > hall_fault > en_req==0 > target compare.
- IDLE: motor_en=0, motor_duty=0. If en_req=1, go to RAMP.
- RAMP: motor_en=1. Ramp timer counts 0..RAMP_DIV-1; on terminal count, motor_duty moves toward target by min(RAMP_STEP, |target-motor_duty|), never overshooting. Unsigned arithmetic, no wrap, clamped at 0 and 2^W-1. When motor_duty==target, go to RUN. The ramp timer clears on entering RAMP.
- RUN: motor_duty held. On entry, retry count clears. A target change returns to RAMP (both up and down).
- en_req=0 in RAMP/RUN: next cycle IDLE, motor_en=0, motor_duty=0 immediately (no ramp-down).
- hall_fault=1 in RAMP/RUN: next cycle FAULT_WAIT; motor_en=0, motor_duty=0; retry count++; holdoff timer=0.
- FAULT_WAIT: counts FAULT_HOLDOFF clocks, then:
  - if retry count>=MAX_RETRIES, go to LOCKOUT;
  - else if hall_fault=1, restart holdoff and retry count++;
  - else if en_req=1, go to RAMP from duty 0;
  - else go to IDLE.
- LOCKOUT: motor outputs 0, fault_latched=1. clear_fault clears retry count and goes to IDLE. hall_fault is ignored.
- Sampling: free-running timer, all states, period SAMPLE_PERIOD. On terminal count, in the same cycle:
  - enc_snapshot/hall_snapshot capture the inputs;
  - sample_valid=1;
  - motor_reset_counts=1 (one cycle).
  Snapshots hold their values otherwise. Captured values are pre-reset counts.
- No combinational input-to-output paths; all outputs registered.

Test Plan:
- Reset/IDLE: assert rst mid-RAMP at duty 200 -> next cycle motor_en=0, motor_duty=0, state=0, sample_valid=0.
- Ramp up: cmd_en=1, cmd_duty=10, RAMP_DIV=4 -> duty 0,4,8,10 at 4-clock intervals; state RAMP->RUN when duty=10; no overshoot.
- Ramp down: from RUN at 100, cmd_duty=90 -> duty 96,92,90, then RUN; cmd_en=0 from RUN -> duty 0 next cycle, state IDLE.
- Fault retry: hall_fault pulse in RUN -> FAULT_WAIT, outputs 0 for FAULT_HOLDOFF clocks, then RAMP from 0; reaching RUN clears retry count.
- Lockout: hall_fault held high, MAX_RETRIES=3 -> three holdoff periods then state=4, fault_latched=1; clear_fault -> IDLE, fault_latched=0.
- Sampling: enc_count=1234, hall_count=17, SAMPLE_PERIOD=8 -> every 8th clock sample_valid=1 and motor_reset_counts=1 for one cycle, snapshots equal 1234/17; pulses continue in LOCKOUT.
